// File: rtl/aux_run_controller_pkg.sv
`default_nettype none
// ============================================================================
// aux_run_controller_pkg : run-control state encoding, defaults and helpers
// Rev 1.0
// ============================================================================
package aux_run_controller_pkg;

   localparam int DEFAULT_DEBOUNCE_CNT = 4;
   localparam int DEFAULT_CNT_BIT      = 3;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HALT  = 2'd1,
      ST_STEP  = 2'd2,
      ST_BREAK = 2'd3
   } run_state_t;

   function automatic logic bp_match(
      input logic        bp_en,
      input logic [31:0] pc,
      input logic [31:0] bp_addr,
      input logic        bp_skip
   );
      return bp_en && (pc == bp_addr) && !bp_skip;
   endfunction

   function automatic run_state_t resume_target(input logic step_mode);
      return step_mode ? ST_STEP : ST_RUN;
   endfunction

endpackage
`default_nettype wire

// File: rtl/aux_run_controller_if.sv
`default_nettype none
// ============================================================================
// aux_run_controller_if : board/core side signals of the run controller
// Rev 1.0
// ============================================================================
interface aux_run_controller_if;

   logic        resume;
   logic        step_mode;
   logic        bp_en;
   logic [31:0] bp_addr;
   logic [31:0] pc;
   logic        halt;
   logic        en;
   logic [1:0]  state;
   logic        bp_skip;

   modport master (
      output resume, step_mode, bp_en, bp_addr, pc, halt,
      input  en, state, bp_skip
   );

   modport slave (
      input  resume, step_mode, bp_en, bp_addr, pc, halt,
      output en, state, bp_skip
   );

endinterface
`default_nettype wire

// File: rtl/aux_run_controller_debounce.sv
`default_nettype none
// ============================================================================
// aux_run_controller_debounce : 2-flop sync, debounce counter, rising pulse
// Rev 1.0
// ============================================================================
module aux_run_controller_debounce #(
   parameter int DebounceCnt = 4,
   parameter int CntBit      = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic pulse
);

   logic              sync1;
   logic              sync2;
   logic              level;
   logic [CntBit-1:0] cnt;
   logic              cnt_done;

   assign cnt_done = (cnt == CntBit'(DebounceCnt - 1));

   // Pulse fires in the cycle whose edge flips the level low->high.
   assign pulse = sync2 && !level && cnt_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt_done) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/aux_run_controller.sv
`default_nettype none
// ============================================================================
// aux_run_controller : core enable sequencer (halt/resume/step/breakpoint)
// Rev 1.0
// ============================================================================
module aux_run_controller
   import aux_run_controller_pkg::*;
#(
   parameter int DebounceCnt = DEFAULT_DEBOUNCE_CNT,
   parameter int CntBit      = DEFAULT_CNT_BIT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   aux_run_controller_if.slave  bus
);

   run_state_t state;
   logic       bp_skip;
   logic       bp_hit;
   logic       en;
   logic       resume_pulse;

   aux_run_controller_debounce #(
      .DebounceCnt (DebounceCnt),
      .CntBit      (CntBit)
   ) u_resume_db (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (bus.resume),
      .pulse (resume_pulse)
   );

   assign bp_hit = bp_match(bus.bp_en, bus.pc, bus.bp_addr, bp_skip);

   // The instruction at the breakpoint must not execute on the hit cycle.
   assign en = ((state == ST_RUN) && !bp_hit) || (state == ST_STEP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_RUN;
         bp_skip <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (bus.halt && en) begin
                  state <= ST_HALT;
               end else if (bp_hit) begin
                  state <= ST_BREAK;
               end else if (bus.step_mode) begin
                  state <= ST_HALT;
               end
            end
            ST_STEP: begin
               state <= ST_HALT;
            end
            ST_HALT, ST_BREAK: begin
               if (resume_pulse) begin
                  state <= resume_target(bus.step_mode);
               end
            end
            default: begin
               state <= ST_RUN;
            end
         endcase

         // Skip covers exactly the one instruction executed after leaving BREAK.
         if ((state == ST_BREAK) && resume_pulse) begin
            bp_skip <= 1'b1;
         end else if (en) begin
            bp_skip <= 1'b0;
         end
      end
   end

   assign bus.en      = en;
   assign bus.state   = state;
   assign bus.bp_skip = bp_skip;

endmodule
`default_nettype wire

// File: tb/tb_aux_run_controller.sv
`default_nettype none
// ============================================================================
// tb_aux_run_controller : directed scoreboard bench for aux_run_controller
// Rev 1.0
// ============================================================================
module tb_aux_run_controller;

   localparam logic [1:0] RUN = 2'd0;
   localparam logic [1:0] HLT = 2'd1;
   localparam logic [1:0] STP = 2'd2;
   localparam logic [1:0] BRK = 2'd3;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   aux_run_controller_if bus();

   aux_run_controller #(
      .DebounceCnt (4),
      .CntBit      (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      string      tag;
      logic [3:0] exp;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed state/en/bp_skip=%b expected %b", tag, obs, exp);
      end
   endtask

   // Expected outputs for the current cycle are compared on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.tag, {bus.state, bus.en, bus.bp_skip}, e.exp);
      end
   end

   task automatic cyc(input string tag, input logic [1:0] st, input logic e, input logic sk);
      exp_t x;
      x.tag = tag;
      x.exp = {st, e, sk};
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   // Raise the button; state holds for 2 sync + 4 debounce cycles.
   task automatic press(input string tag, input logic [1:0] hold_st);
      bus.resume = 1'b1;
      repeat (6) cyc(tag, hold_st, 1'b0, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n         = 1'b0;
      bus.resume    = 1'b0;
      bus.step_mode = 1'b0;
      bus.bp_en     = 1'b0;
      bus.bp_addr   = 32'h0;
      bus.pc        = 32'h0;
      bus.halt      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset", {bus.state, bus.en, bus.bp_skip}, {RUN, 1'b1, 1'b0});
      rst_n = 1'b1;

      for (int i = 0; i < 100; i++) begin
         bus.pc = 32'(i * 4);
         cyc("free_run", RUN, 1'b1, 1'b0);
      end

      bus.halt = 1'b1; cyc("halt_req", RUN, 1'b1, 1'b0);
      bus.halt = 1'b0; cyc("halted",   HLT, 1'b0, 1'b0);
      press("resume_wait", HLT);
      repeat (4) cyc("resumed", RUN, 1'b1, 1'b0);
      bus.resume = 1'b0;
      repeat (8) cyc("release_run", RUN, 1'b1, 1'b0);

      bus.halt = 1'b1;
      cyc("halt_held_req", RUN, 1'b1, 1'b0);
      cyc("halt_held",     HLT, 1'b0, 1'b0);
      press("halt_held_wait", HLT);
      cyc("halt_held_one",   RUN, 1'b1, 1'b0);
      cyc("halt_held_again", HLT, 1'b0, 1'b0);
      bus.halt   = 1'b0;
      bus.resume = 1'b0;
      repeat (8) cyc("halt_release", HLT, 1'b0, 1'b0);

      bus.step_mode = 1'b1;
      for (int p = 0; p < 3; p++) begin
         press("step_wait", HLT);
         cyc("step_exec", STP, 1'b1, 1'b0);
         bus.resume = 1'b0;
         repeat (8) cyc("step_done", HLT, 1'b0, 1'b0);
      end

      bus.step_mode = 1'b0;
      bus.pc        = 32'h10;
      press("to_run", HLT);
      cyc("to_run", RUN, 1'b1, 1'b0);
      bus.resume = 1'b0;
      repeat (8) cyc("to_run_release", RUN, 1'b1, 1'b0);

      bus.bp_en   = 1'b1;
      bus.bp_addr = 32'h0000_0040;
      bus.pc = 32'h8000_0040; cyc("bp_high_bits", RUN, 1'b1, 1'b0);
      bus.pc = 32'h0000_003C; cyc("bp_before",    RUN, 1'b1, 1'b0);
      bus.pc = 32'h0000_0040; cyc("bp_hit",       RUN, 1'b0, 1'b0);
      repeat (2) cyc("bp_break", BRK, 1'b0, 1'b0);
      press("bp_wait", BRK);
      cyc("bp_skip_exec", RUN, 1'b1, 1'b1);
      bus.resume = 1'b0;
      bus.pc     = 32'h44;
      cyc("bp_skip_clr", RUN, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) begin
         bus.pc = 32'h48 + 32'(i * 4);
         cyc("bp_after", RUN, 1'b1, 1'b0);
      end
      bus.pc = 32'h40;
      cyc("bp_rehit",   RUN, 1'b0, 1'b0);
      cyc("bp_rebreak", BRK, 1'b0, 1'b0);

      bus.step_mode = 1'b1;
      bus.resume = 1'b1; cyc("bounce", BRK, 1'b0, 1'b0);
      bus.resume = 1'b0; cyc("bounce", BRK, 1'b0, 1'b0);
      bus.resume = 1'b1;
      repeat (6) cyc("bounce", BRK, 1'b0, 1'b0);
      cyc("bounce_step", STP, 1'b1, 1'b1);
      repeat (6) cyc("bounce_held", HLT, 1'b0, 1'b0);
      bus.resume = 1'b0;
      repeat (8) cyc("bounce_release", HLT, 1'b0, 1'b0);

      bus.step_mode = 1'b0;
      bus.bp_en     = 1'b0;
      press("to_run2", HLT);
      cyc("to_run2", RUN, 1'b1, 1'b0);
      bus.resume = 1'b0;
      repeat (8) cyc("to_run2_release", RUN, 1'b1, 1'b0);
      bus.resume = 1'b1;
      repeat (10) cyc("run_press_ignored", RUN, 1'b1, 1'b0);
      bus.resume = 1'b0;
      repeat (3) cyc("run_press_release", RUN, 1'b1, 1'b0);
      bus.halt = 1'b1; cyc("not_queued_req", RUN, 1'b1, 1'b0);
      bus.halt = 1'b0;
      repeat (8) cyc("not_queued", HLT, 1'b0, 1'b0);

      bus.pc = 32'h10;
      press("to_run3", HLT);
      cyc("to_run3", RUN, 1'b1, 1'b0);
      bus.resume = 1'b0;
      repeat (8) cyc("to_run3_release", RUN, 1'b1, 1'b0);
      bus.bp_en = 1'b1;
      bus.pc    = 32'h40;
      bus.halt  = 1'b1; cyc("halt_and_bp",     RUN, 1'b0, 1'b0);
      bus.halt  = 1'b0; cyc("halt_and_bp_brk", BRK, 1'b0, 1'b0);

      press("rst_wait", BRK);
      check("skip_pending", {bus.state, bus.en, bus.bp_skip}, {RUN, 1'b1, 1'b1});
      #2;
      rst_n      = 1'b0;
      bus.resume = 1'b0;
      #1;
      // pc still at the breakpoint with skip cleared, so en is held low.
      check("async_reset", {bus.state, bus.en, bus.bp_skip}, {RUN, 1'b0, 1'b0});
      bus.pc = 32'h44;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.pc = 32'h44 + 32'(i * 4);
         cyc("post_reset", RUN, 1'b1, 1'b0);
      end

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
